req_index_encoder: RTL



---
 rtl/req_index_encoder_pkg.sv | 9 +
 rtl/req_index_encoder_lsb_prio_enc.sv | 26 ++
 rtl/req_index_encoder.sv | 84 ++++++++
 3 files changed

// File: rtl/req_index_encoder_pkg.sv
// Shared definitions for the request-vector to binary-index serializer.
package req_index_encoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/req_index_encoder_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index, isolated one-hot and non-zero flag.
// Purely combinational; no latency, no backpressure.
module lsb_prio_enc #(
    parameter int n = 2,
    parameter int m = 4
) (
    input  logic [m-1:0] v,
    output logic [n-1:0] idx,
    output logic [m-1:0] onehot,
    output logic         any
);

    // Scan from the top so the lowest set bit wins the last assignment.
    always_comb begin
        idx = '0;
        for (int i = m - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[n-1:0];
            end
        end
    end

    assign onehot = v & (~v + m'(1));
    assign any    = |v;

endmodule

// File: rtl/req_index_encoder.sv
// Serializes a captured request vector into binary indices, lowest bit first.
// Index valid the cycle after load, one per cycle; outputs hold while out_ready is low.
module req_index_encoder
    import req_index_encoder_pkg::*;
#(
    parameter int n = 2,
    parameter int m = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [m-1:0] in_vec,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_idx,
    output logic [m-1:0] out_onehot,
    output logic         done
);

    state_t         state, state_nxt;
    logic [m-1:0]   pending, pending_nxt;
    logic           done_nxt;
    logic [n-1:0]   enc_idx;
    logic [m-1:0]   enc_onehot;
    logic           enc_any;
    logic [m-1:0]   remaining;

    lsb_prio_enc #(.n(n), .m(m)) u_enc (
        .v      (pending),
        .idx    (enc_idx),
        .onehot (enc_onehot),
        .any    (enc_any)
    );

    assign remaining = pending & ~enc_onehot;

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        done_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    pending_nxt = in_vec;
                    if (in_vec != '0) begin
                        state_nxt = EMIT;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_nxt = remaining;
                    if (remaining == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pending <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            done    <= done_nxt;
        end
    end

    // Decoded from registered state only, so outputs are stable between edges.
    assign busy       = (state == EMIT);
    assign out_valid  = (state == EMIT) && enc_any;
    assign out_idx    = out_valid ? enc_idx : '0;
    assign out_onehot = out_valid ? enc_onehot : '0;

endmodule
